// File: rtl/jt51_dac_ser_pkg.sv
// Shared constants and frame layout for the YM3012-style serial DAC stream.
// Imported by the interface, the encoder and the top.
package jt51_dac_ser_pkg;

  localparam int OP_W      = 14;
  localparam int FRAME_LEN = 16;
  localparam int PAD       = 3;
  localparam int MANT_W    = 10;
  localparam int EXP_W     = 3;
  localparam int CNT_W     = 5;

  localparam logic [CNT_W-1:0] CNT_LOAD = 5'd0;
  localparam logic [CNT_W-1:0] CNT_SH1  = 5'd16;
  localparam logic [CNT_W-1:0] CNT_SH2  = 5'd0;

  // One channel frame; bit 0 leaves first, so the pad sits at the bottom.
  typedef struct packed {
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic [PAD-1:0]    pad;
  } frame_t;

  function automatic frame_t make_frame(input logic [MANT_W-1:0] mant,
                                        input logic [EXP_W-1:0] exp);
    frame_t f;
    f.exp  = exp;
    f.mant = mant;
    f.pad  = '0;
    return f;
  endfunction

endpackage

// File: rtl/jt51_dac_ser_if.sv
// Operator-stream input and serial DAC output bundle.
// master drives the slot stream, slave is the serialiser.
interface jt51_dac_ser_if;
  import jt51_dac_ser_pkg::*;

  logic                   cen;
  logic                   zero;
  logic signed [OP_W-1:0] op_in;
  logic                   carrier;
  logic                   l_en;
  logic                   r_en;
  logic                   so;
  logic                   sh1;
  logic                   sh2;

  modport master (output cen, zero, op_in, carrier, l_en, r_en,
                  input  so, sh1, sh2);
  modport slave  (input  cen, zero, op_in, carrier, l_en, r_en,
                  output so, sh1, sh2);
endinterface

// File: rtl/jt51_dac_ser_enc.sv
// Combinational saturate to 16 bits and linear -> 10-bit mantissa / 3-bit exponent.
// The smallest shift keeping the mantissa sign-correct wins.
module jt51_dac_enc
  import jt51_dac_ser_pkg::*;
#(
  parameter int ACC_W = 19
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic [MANT_W-1:0]       mant,
  output logic [EXP_W-1:0]        exp
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  logic [15:0] v;
  logic [15:0] top_bits;
  logic [2:0]  shift;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    v        = acc[15:0];
    top_bits = '0;
    shift    = 3'd6;
    if (acc > SAT_MAX)      v = 16'h7FFF;
    else if (acc < SAT_MIN) v = 16'h8000;
    // Arithmetic shift leaves all-0 or all-1 exactly when v[15:9+i] are equal.
    for (int i = 6; i >= 0; i--) begin
      top_bits = $signed(v) >>> (9 + i);
      if (top_bits == 16'h0000 || top_bits == 16'hFFFF) shift = 3'(i);
    end
    mant = MANT_W'(v >> shift);
    exp  = shift + 3'd1;
  end

endmodule

// File: rtl/jt51_dac_ser.sv
// Sums carrier slots per 32-slot frame, encodes L/R and shifts them out LSB first
// with SH1/SH2 latch strobes; everything advances on cen only.
module jt51_dac_ser
  import jt51_dac_ser_pkg::*;
#(
  parameter int ACC_W = 19
) (
  input  logic           clk,
  input  logic           rst,
  jt51_dac_ser_if.slave  bus
);

  logic signed [ACC_W-1:0] acc_l, acc_r, hold_l, hold_r;
  logic signed [ACC_W-1:0] add, add_l, add_r;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic [2*FRAME_LEN-1:0]  sr;
  logic                    sh1_q, sh2_q;
  logic [MANT_W-1:0]       mant_l, mant_r;
  logic [EXP_W-1:0]        exp_l, exp_r;
  frame_t                  frame_l, frame_r;

  always_comb begin
    add      = bus.carrier ? {{(ACC_W-OP_W){bus.op_in[OP_W-1]}}, bus.op_in} : '0;
    add_l    = bus.l_en ? add : '0;
    add_r    = bus.r_en ? add : '0;
    cnt_next = bus.zero ? '0 : cnt + 5'd1;
    frame_l  = make_frame(mant_l, exp_l);
    frame_r  = make_frame(mant_r, exp_r);
  end

  jt51_dac_enc #(.ACC_W(ACC_W)) u_enc_l (.acc(hold_l), .mant(mant_l), .exp(exp_l));
  jt51_dac_enc #(.ACC_W(ACC_W)) u_enc_r (.acc(hold_r), .mant(mant_r), .exp(exp_r));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_l  <= '0;
      acc_r  <= '0;
      hold_l <= '0;
      hold_r <= '0;
      cnt    <= '0;
      sr     <= '0;
      sh1_q  <= 1'b0;
      sh2_q  <= 1'b0;
    end else if (bus.cen) begin
      // NOTE: non-blocking so hold_x captures acc_x from before this edge's update.
      cnt <= cnt_next;
      if (bus.zero) begin
        hold_l <= acc_l;
        hold_r <= acc_r;
        acc_l  <= add_l;
        acc_r  <= add_r;
      end else begin
        acc_l <= acc_l + add_l;
        acc_r <= acc_r + add_r;
      end
      if (cnt == CNT_LOAD) sr <= {frame_r, frame_l};
      else                 sr <= sr >> 1;
      // Strobes are decoded from the next count so they are clean flop outputs.
      sh1_q <= (cnt_next == CNT_SH1);
      sh2_q <= (cnt_next == CNT_SH2);
    end
  end

  assign bus.so  = sr[0];
  assign bus.sh1 = sh1_q;
  assign bus.sh2 = sh2_q;

endmodule
